// File: rtl/fc_mac_sequencer.sv
// fc_mac_sequencer: FC-layer compute stage. Streams activations, fetches one
// weight column per activation from the FC weight memory, and accumulates
// parallel_fc_PE fixed-point neuron sums. The packed sums are then presented
// on a valid/ready output.
module fc_mac_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int parallel_fc_PE = 32,
  parameter int fc_columns     = 100,
  parameter int FRAC_BITS      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [ADDR_WIDTH-1:0]                address_fc,
  output logic                                 read_en_MM_fc,
  output logic                                 enable_MM_out_fc,
  input  logic [DATA_WIDTH*parallel_fc_PE-1:0] dataMainMemo_fc,
  output logic [DATA_WIDTH*parallel_fc_PE-1:0] out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(fc_columns - 1);

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   cnt_reg;
  logic [ADDR_WIDTH-1:0]   address_reg;
  logic                    s1_valid_reg;
  logic [DATA_WIDTH-1:0]   x_reg;
  logic                    in_ready_reg;
  logic                    enable_reg;
  logic                    out_valid_reg;
  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   acc_reg  [parallel_fc_PE];
  logic [DATA_WIDTH-1:0]   mac_term [parallel_fc_PE];

  // Full-width signed product, rescaled by FRAC_BITS, truncated back to
  // DATA_WIDTH; the accumulator add wraps, so no saturation anywhere.
  function automatic logic [DATA_WIDTH-1:0] scaled_product(
    input logic signed [DATA_WIDTH-1:0] w,
    input logic signed [DATA_WIDTH-1:0] x
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(w) * (2*DATA_WIDTH)'(x);
    scaled_product = DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < parallel_fc_PE; gi++) begin : g_lane
      assign mac_term[gi] = scaled_product(dataMainMemo_fc[gi*DATA_WIDTH +: DATA_WIDTH], x_reg);
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = acc_reg[gi];
    end
  endgenerate

  assign in_ready         = in_ready_reg;
  assign address_fc       = address_reg;
  assign read_en_MM_fc    = s1_valid_reg;
  assign enable_MM_out_fc = enable_reg;
  assign out_valid        = out_valid_reg;
  assign busy             = busy_reg;

  // Sequencer FSM, activation capture, and MAC stage. Weights requested at
  // edge t arrive from memory at the following falling edge, so the MAC runs
  // one edge after the transfer that requested them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      address_reg   <= '0;
      s1_valid_reg  <= 1'b0;
      x_reg         <= '0;
      in_ready_reg  <= 1'b0;
      enable_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      for (int k = 0; k < parallel_fc_PE; k++) acc_reg[k] <= '0;
    end else begin
      if (s1_valid_reg) begin
        for (int k = 0; k < parallel_fc_PE; k++) acc_reg[k] <= acc_reg[k] + mac_term[k];
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            s1_valid_reg <= 1'b0;
            in_ready_reg <= 1'b1;
            enable_reg   <= 1'b1;
            busy_reg     <= 1'b1;
            for (int k = 0; k < parallel_fc_PE; k++) acc_reg[k] <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            x_reg        <= in_data;
            address_reg  <= cnt_reg;
            s1_valid_reg <= 1'b1;
            cnt_reg      <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_COL) begin
              state_reg    <= DRAIN;
              in_ready_reg <= 1'b0;
            end
          end else begin
            s1_valid_reg <= 1'b0;
          end
        end
        DRAIN: begin
          s1_valid_reg  <= 1'b0;
          enable_reg    <= 1'b0;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fc_mac_sequencer.md
# fc_mac_sequencer

Fully-connected layer compute stage directly downstream of the FC weight memory (`weights_Memory`). It accepts a stream of input activations, one per weight-matrix column. For each activation it drives the column address and read/output enables to the weight memory, then multiplies the returned `parallel_fc_PE` weights by the activation and accumulates them into `parallel_fc_PE` neuron sums. After `fc_columns` activations it presents the packed sums on a valid/ready output handshake.

## Interface
- `DATA_WIDTH`, 32: width of weights, activations and accumulators (signed two's complement, fixed point).
- `ADDR_WIDTH`, 9: width of the weight-memory column address.
- `parallel_fc_PE`, 32: number of neurons computed in parallel (lanes).
- `fc_columns`, 100: activations per output vector; must be ≤ 2^ADDR_WIDTH.
- `FRAC_BITS`, 16: fractional bits of the fixed-point format (Q16.16 by default).

Ports:
- `clk` in 1: single clock, rising-edge. The weight memory updates on the falling edge of the same clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse that begins a new vector. Honoured only in IDLE.
- `in_data` in DATA_WIDTH: activation x[j].
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts `in_data`. A transfer occurs when `in_valid && in_ready`.
- `address_fc` out ADDR_WIDTH: column index j to the weight memory.
- `read_en_MM_fc` out 1: weight-memory read enable.
- `enable_MM_out_fc` out 1: weight-memory output-drive enable.
- `dataMainMemo_fc` in DATA_WIDTH*parallel_fc_PE: packed weights from memory. Lane k occupies bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `out_data` out DATA_WIDTH*parallel_fc_PE: packed neuron sums, same lane layout as `dataMainMemo_fc`.
- `out_valid` out 1: `out_data` is complete.
- `out_ready` in 1: consumer accepts `out_data`.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` → RUN.
  - Clear all accumulators, column counter `cnt` and `s1_valid` on the same edge.
- RUN:
  - `in_ready`=1.
  - On each transfer: latch `x_reg`=`in_data`, `address_fc`=`cnt`, `s1_valid`=1, then `cnt`++.
  - With no transfer, `s1_valid`=0.
  - A transfer with `cnt`==`fc_columns`-1 → DRAIN.
- DRAIN: `in_ready`=0, one cycle; performs the final MAC, then → DONE.
- DONE:
  - `out_valid`=1 and `out_data` held stable.
  - `out_valid && out_ready` → IDLE; accumulators retain their values until the next `start`.
- MAC stage: on any rising edge with `s1_valid`=1, for each lane k: `acc[k] += trunc_DW((w[k] * x_reg) >>> FRAC_BITS)`.
  - The product is a full 2*DATA_WIDTH signed multiply; the shift is arithmetic.
  - Truncation keeps the low DATA_WIDTH bits.
  - Addition wraps modulo 2^DATA_WIDTH. There is no saturation.
- `read_en_MM_fc` = `s1_valid`. When it is 0 the memory returns zeros, and no MAC is performed in that case.
- `enable_MM_out_fc` = 1 in RUN and DRAIN, 0 in IDLE and DONE, so the memory bus is released (high-Z).
- `out_data` is driven directly from the accumulators.
- `start` outside IDLE is ignored.
- `in_valid` outside RUN is ignored; no transfer occurs.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`, `read_en_MM_fc`, `enable_MM_out_fc`, `out_valid`, `busy` all 0.
  - `address_fc` 0 and `out_data` 0.
  - `cnt`, `s1_valid`, `x_reg` 0.
- Reset mid-operation: everything returns to the reset values immediately, without waiting for a clock edge. Partial sums are discarded.
- Weight path:
  - `address_fc` and `read_en_MM_fc` are registered at rising edge t.
  - The memory registers the weights at the following falling edge.
  - The MAC samples `dataMainMemo_fc` at rising edge t+1.
- Throughput is one activation per cycle. Bubbles (`in_valid`=0) stall only the counter.
- Latency:
  - `start` sampled at edge E0.
  - With `in_valid` held high, transfers occur at E1…E_N (N=`fc_columns`).
  - DRAIN occupies the cycle after E_N; `out_valid` rises after edge E_{N+1}.
- `out_valid` stays high until an edge with `out_ready`=1. `busy` falls on that same edge.

## Test plan
All scenarios use `fc_columns`=4, `parallel_fc_PE`=2, Q16.16.

- **Basic accumulation.** Weights all 0x00010000; inputs 1.0, 2.0, 3.0, 4.0 back-to-back → both lanes 0x000A0000. `address_fc` sequence is 0,1,2,3 with `read_en_MM_fc`=1 each cycle; `out_valid` rises 5 edges after `start`.
- **Bubbles.** Same data with `in_valid` toggling 1,0,1,0… → identical 0x000A0000 result. `read_en_MM_fc`=0 in bubble cycles, and the MAC is unchanged by the zero memory data.
- **Signed arithmetic.** Lane 0 weight 0xFFFF8000 (-0.5), lane 1 weight 0x00020000 (2.0); inputs all 2.0 → lane 0 = 0xFFFC0000 (-4.0), lane 1 = 0x00100000 (16.0).
- **Wrap-around.** Weights 0x7FFF0000; inputs all 2.0 → each product is 0xFFFE0000. The sum of 4 is 0xFFF80000, wrapped with no saturation.
- **Output backpressure.** Hold `out_ready`=0 for 10 cycles in DONE → `out_data` stable, `in_ready`=0, and `start` pulses ignored. Raising `out_ready` → IDLE the next edge, with `busy`=0.
- **Reset mid-run.** Assert `reset` after 2 transfers → all outputs go to 0 and the state goes to IDLE with no clock edge needed. A following clean run produces the exact expected sums, with no residue from the aborted run.
